pll_avalon_master: RTL and testbench
====================================

Name: pll_avalon_master

Overview:
- Avalon-MM master sequencer that drives the PLL register slave, the 3-bit-address, 16-bit-data block with status at even addresses, control at 0x1 and a resetrequest output.
- Accepts single commands from local control logic: write, read, or poll-until-match. Issues them on the bus and returns one response per command.
- Holds off all bus traffic while the slave's resetrequest is asserted.
- Sits between board-level bring-up logic and the PLL slave port.

Parameters:
- ADDR_W, 3, bus address width
- DATA_W, 16, bus data width
- POLL_LIMIT, 255, maximum reads per poll command (1..65535)
- POLL_GAP, 4, idle cycles between consecutive poll reads (0..255)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved (treated as read)
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data; for poll, the match value
- cmd_mask  in  DATA_W  poll compare mask
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DATA_W  captured read data (0 for writes)
- rsp_status  out  2  00 ok, 01 poll timeout, 10 aborted
- pll_resetrequest  in  1  slave resetrequest; high = slave not ready
- address  out  ADDR_W  Avalon address
- chipselect  out  1  Avalon chipselect
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  DATA_W  Avalon writedata
- readdata  in  DATA_W  Avalon readdata; valid in the cycle waitrequest=0 with read=1
- waitrequest  in  1  Avalon waitrequest; tie 0 for zero-wait slaves

Behaviour:
- Reset (reset_n=0, async): state HOLD; all outputs 0, including cmd_ready, rsp_valid, rsp_data, rsp_status and every bus signal. Poll counter and gap counter are 0.
- All outputs are registered. No combinational path from any input to any output.
- State HOLD: stay while pll_resetrequest=1. When it is 0 at a clock edge, go to IDLE. cmd_ready rises in the following cycle.
- State IDLE: cmd_ready=1.
  - On handshake, latch op, addr, wdata and mask; clear poll_cnt; cmd_ready=0.
  - Next cycle goes to XFER with chipselect=1, address=addr, and write=1/writedata=wdata or read=1.
- State XFER: bus signals stay stable while waitrequest=1. The transfer completes at the first edge with waitrequest=0, and bus signals drop the next cycle.
  - Minimum command-to-response latency with waitrequest=0: handshake edge N, bus active cycle N+1, rsp_valid in cycle N+2.
  - Write done: RESP with rsp_data=0 and status 00.
  - Read done: capture readdata into rsp_data; RESP with status 00.
  - Poll done: capture readdata and increment poll_cnt (16-bit, saturating).
    - If (readdata & mask) == (wdata & mask), go to RESP with status 00.
    - Else if poll_cnt == POLL_LIMIT, go to RESP with status 01 and rsp_data = last read value.
    - Else go to GAP.
- State GAP: count POLL_GAP idle cycles, then XFER (read). POLL_GAP=0 means XFER immediately follows the previous read.
- State RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data and rsp_status hold their values until the next response.
- Abort: pll_resetrequest=1 in XFER, GAP or RESP-pending causes the following:
  - Bus signals go to 0 next cycle, even if waitrequest=1. The transaction is abandoned.
  - One rsp_valid is issued with status 10 and rsp_data=0, then the block enters HOLD.
  - pll_resetrequest=1 in IDLE means cmd_ready=0 next cycle and the block enters HOLD with no response.
- Simultaneous cmd_valid and pll_resetrequest rising in IDLE: the handshake registered at that edge wins. That command then aborts per the rule above.
- Exactly one response per accepted command. Never more than one outstanding.
- Reset mid-operation: immediate return to reset values. No response is emitted for the in-flight command.

Test Plan:
- Bring-up: hold pll_resetrequest=1 for 70 cycles after reset -> cmd_ready stays 0, no bus activity. Release -> cmd_ready=1 one cycle after the release edge.
- Write 0x0002 to addr 1, waitrequest=0 -> write=1, chipselect=1, address=1, writedata=0x0002 for exactly one cycle. rsp_valid two cycles after the handshake, rsp_status=00.
- Read addr 0 with waitrequest held high 3 cycles and readdata=0xA5C3 on release -> read held 4 cycles, rsp_data=0xA5C3, status 00.
- Poll addr 0, mask 0x0001, match 0x0001, POLL_GAP=4, bit0 set on the 3rd read -> exactly 3 read pulses spaced 5 cycles apart, status 00.
- Poll with no match, POLL_LIMIT=5 -> exactly 5 reads, then rsp_status=01 with rsp_data=last readdata.
- Assert pll_resetrequest during the waitrequest stall of a write -> bus drops next cycle, one rsp_valid with status 10, cmd_ready=0 until release.

Source files
------------

// File: rtl/pll_avalon_master.sv
`default_nettype none
// ============================================================================
// Module      : pll_avalon_master
// Description : Avalon-MM master sequencer for the PLL register slave.
//               Accepts single write/read/poll commands. Issues each one on
//               the bus and returns exactly one response per command.
//               Bus traffic is held off while the slave requests reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_avalon_master #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16,
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  // slave status
  input  logic              pll_resetrequest,
  // Avalon-MM master
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_IDLE = 3'd1,
    S_XFER = 3'd2,
    S_GAP  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_POLL    = 2'b10;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [15:0] LIMIT_C    = 16'(POLL_LIMIT);
  // Last gap count before the next poll read; unused when POLL_GAP is 0.
  localparam logic [7:0]  GAP_LAST_C = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          rsp_status_q;
  logic [ADDR_W-1:0]   address_q;
  logic                chipselect_q;
  logic                read_q;
  logic                write_q;
  logic [DATA_W-1:0]   writedata_q;

  // latched command
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mask_q;
  logic [15:0]         poll_cnt_q;
  logic [7:0]          gap_cnt_q;

  logic [15:0]         poll_cnt_d;
  logic                poll_hit_d;
  logic                poll_last_d;

  // Poll bookkeeping for the read completing in this cycle (count saturates).
  always_comb begin
    poll_cnt_d  = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    poll_hit_d  = ((readdata ^ wdata_q) & mask_q) == '0;
    poll_last_d = (poll_cnt_d == LIMIT_C);
  end

  // Sequencer: one command at a time, every output driven from a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HOLD;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      address_q    <= '0;
      chipselect_q <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      op_q         <= OP_WRITE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          cmd_ready_q <= 1'b0;
          if (!pll_resetrequest) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end

        S_IDLE: begin
          // An accepted command wins over a simultaneous reset request; it is
          // then aborted from XFER on the following edge.
          if (cmd_valid && cmd_ready_q) begin
            op_q         <= cmd_op;
            addr_q       <= cmd_addr;
            wdata_q      <= cmd_wdata;
            mask_q       <= cmd_mask;
            poll_cnt_q   <= '0;
            cmd_ready_q  <= 1'b0;
            chipselect_q <= 1'b1;
            address_q    <= cmd_addr;
            write_q      <= (cmd_op == OP_WRITE);
            read_q       <= (cmd_op != OP_WRITE);
            writedata_q  <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
            state_q      <= S_XFER;
          end else if (pll_resetrequest) begin
            cmd_ready_q <= 1'b0;
            state_q     <= S_HOLD;
          end
        end

        S_XFER: begin
          if (pll_resetrequest) begin
            // Abandon the transfer even if the slave is still stalling.
            chipselect_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_ABORT;
            state_q      <= S_HOLD;
          end else if (!waitrequest) begin
            if (op_q == OP_POLL && !poll_hit_d && !poll_last_d) begin
              poll_cnt_q <= poll_cnt_d;
              gap_cnt_q  <= '0;
              if (POLL_GAP == 0) begin
                // Back-to-back reads: keep the bus asserted.
                state_q <= S_XFER;
              end else begin
                chipselect_q <= 1'b0;
                read_q       <= 1'b0;
                address_q    <= '0;
                state_q      <= S_GAP;
              end
            end else begin
              chipselect_q <= 1'b0;
              read_q       <= 1'b0;
              write_q      <= 1'b0;
              address_q    <= '0;
              writedata_q  <= '0;
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= (op_q == OP_WRITE) ? '0 : readdata;
              rsp_status_q <= (op_q == OP_POLL && !poll_hit_d) ? ST_TIMEOUT : ST_OK;
              if (op_q == OP_POLL) begin
                poll_cnt_q <= poll_cnt_d;
              end
              state_q <= S_RESP;
            end
          end
        end

        S_GAP: begin
          if (pll_resetrequest) begin
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_ABORT;
            gap_cnt_q    <= '0;
            state_q      <= S_HOLD;
          end else if (gap_cnt_q == GAP_LAST_C) begin
            chipselect_q <= 1'b1;
            read_q       <= 1'b1;
            address_q    <= addr_q;
            gap_cnt_q    <= '0;
            state_q      <= S_XFER;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end

        S_RESP: begin
          // The response is already on the port; a reset request here only
          // redirects to HOLD instead of reopening the command port.
          if (pll_resetrequest) begin
            cmd_ready_q <= 1'b0;
            state_q     <= S_HOLD;
          end else begin
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign address    = address_q;
  assign chipselect = chipselect_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_avalon_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_avalon_master
// Description : Directed scoreboard bench for pll_avalon_master. Expected
//               responses are queued at command issue and popped by a
//               separate response monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_avalon_master;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          pll_resetrequest = 1'b1;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          waitrequest = 1'b0;

  pll_avalon_master #(
    .ADDR_W(AW), .DATA_W(DW), .POLL_LIMIT(5), .POLL_GAP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .pll_resetrequest(pll_resetrequest),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  // ---------------- counters and slave model ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_idx = 0;
  int rd_base = 0;
  logic [DW-1:0] rd_tab [8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (chipselect && read && !waitrequest) rd_idx <= rd_idx + 1;
  assign readdata = rd_tab[3'(rd_idx - rd_base)];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    st;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  int n_pushed = 0;
  int rsp_seen = 0;

  task automatic expect_rsp(input logic [DW-1:0] d, input logic [1:0] s, input int c);
    exp_t e;
    e.data = d; e.st = s; e.cyc = c;
    sb.push_back(e);
    n_pushed++;
  endtask

  initial begin : response_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_status", 64'(rsp_status), 64'(e.st));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  int rd_hi = 0;
  int wr_hi = 0;
  int rd_starts = 0;
  int rd_start_cyc [64];
  logic rd_prev = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;

  initial begin : bus_monitor
    forever begin
      @(negedge clk);
      if (read) rd_hi++;
      if (read && !rd_prev) begin
        if (rd_starts < 64) rd_start_cyc[rd_starts] = cyc;
        rd_starts++;
      end
      rd_prev = read;
      if (write) begin
        wr_hi++;
        last_wr_addr = address;
        last_wr_data = writedata;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] mk, output int h);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    h = cyc;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("rsp_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed vectors ----------------
  initial begin : stimulus
    int h, bad, w0, r0, s0;
    for (int i = 0; i < 8; i++) rd_tab[i] = '0;

    // reset and bring-up hold
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({cmd_ready, rsp_valid, rsp_data, rsp_status, chipselect, read, write, address, writedata}),
        64'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (cmd_ready || chipselect || read || write || rsp_valid) bad++;
    end
    chk("hold_quiet", 64'(bad), 64'd0);
    pll_resetrequest = 1'b0;
    chk("ready_before_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_release", 64'(cmd_ready), 64'd1);

    // write 0x0002 to addr 1, zero wait
    w0 = wr_hi;
    issue(2'b00, 3'd1, 16'h0002, 16'h0000, h);
    expect_rsp(16'h0000, 2'b00, h + 1);
    wait_drain();
    chk("write_cycles", 64'(wr_hi - w0), 64'd1);
    chk("write_addr", 64'(last_wr_addr), 64'd1);
    chk("write_data", 64'(last_wr_data), 64'h0002);

    // read addr 0 with three stall cycles
    r0 = rd_hi;
    rd_base = rd_idx;
    rd_tab[0] = 16'hA5C3;
    waitrequest = 1'b1;
    issue(2'b01, 3'd0, 16'h0000, 16'h0000, h);
    expect_rsp(16'hA5C3, 2'b00, h + 4);
    repeat (3) @(posedge clk);
    #1 waitrequest = 1'b0;
    wait_drain();
    chk("read_stall_cycles", 64'(rd_hi - r0), 64'd4);

    // reserved op behaves as a read
    r0 = rd_hi;
    rd_base = rd_idx;
    rd_tab[0] = 16'h1234;
    issue(2'b11, 3'd2, 16'h0000, 16'h0000, h);
    expect_rsp(16'h1234, 2'b00, h + 1);
    wait_drain();
    chk("reserved_read_cycles", 64'(rd_hi - r0), 64'd1);

    // poll: bit0 set on the third read
    s0 = rd_starts;
    rd_base = rd_idx;
    rd_tab[0] = 16'h0000; rd_tab[1] = 16'h0010; rd_tab[2] = 16'h8001;
    issue(2'b10, 3'd0, 16'h0001, 16'h0001, h);
    expect_rsp(16'h8001, 2'b00, h + 11);
    wait_drain();
    chk("poll_read_count", 64'(rd_starts - s0), 64'd3);
    chk("poll_first_read", 64'(rd_start_cyc[s0]), 64'(h));
    chk("poll_spacing_1", 64'(rd_start_cyc[s0 + 1] - rd_start_cyc[s0]), 64'd5);
    chk("poll_spacing_2", 64'(rd_start_cyc[s0 + 2] - rd_start_cyc[s0 + 1]), 64'd5);

    // poll timeout after POLL_LIMIT=5 reads
    s0 = rd_starts;
    rd_base = rd_idx;
    for (int i = 0; i < 8; i++) rd_tab[i] = 16'((i + 1) * 16);
    issue(2'b10, 3'd0, 16'h0001, 16'h0001, h);
    expect_rsp(16'h0050, 2'b01, h + 21);
    wait_drain();
    chk("poll_timeout_reads", 64'(rd_starts - s0), 64'd5);

    // abort during a stalled write
    waitrequest = 1'b1;
    w0 = wr_hi;
    issue(2'b00, 3'd1, 16'hBEEF, 16'h0000, h);
    expect_rsp(16'h0000, 2'b10, h + 2);
    @(posedge clk);
    #1 pll_resetrequest = 1'b1;
    wait_drain();
    chk("abort_bus_drop", 64'({chipselect, write, read}), 64'd0);
    chk("abort_write_cycles", 64'(wr_hi - w0), 64'd2);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready) bad++;
    end
    chk("abort_hold_ready", 64'(bad), 64'd0);
    waitrequest = 1'b0;
    pll_resetrequest = 1'b0;
    @(negedge clk);
    chk("abort_release_ready", 64'(cmd_ready), 64'd1);

    // reset request while idle: no response, port closes then reopens
    pll_resetrequest = 1'b1;
    @(negedge clk);
    chk("idle_req_ready_low", 64'(cmd_ready), 64'd0);
    repeat (3) @(negedge clk);
    pll_resetrequest = 1'b0;
    @(negedge clk);
    chk("idle_req_ready_back", 64'(cmd_ready), 64'd1);

    // recovery write
    issue(2'b00, 3'd1, 16'h0001, 16'h0000, h);
    expect_rsp(16'h0000, 2'b00, h + 1);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("response_count", 64'(rsp_seen), 64'(n_pushed));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
